// File: rtl/rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rx_pkg : serial frame constants, receiver state encoding, parity helper
// Rev 1.0
// ----------------------------------------------------------------------------
package rx_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic logic parity_even(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bit_sync : two-flop synchronizer for one asynchronous input
// Rev 1.0
// ----------------------------------------------------------------------------
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/rx_module.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rx_module : 8E1 serial receiver with bit-centre sampling and error flags
// Rev 1.0
// ----------------------------------------------------------------------------
module rx_module
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  // The detect cycle counts toward the half-bit wait, so START waits one less.
  localparam logic [CNT_W-1:0] CNT_START  = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 rxs;
  logic                 sample;

  bit_sync #(.RESET_VAL(IDLE_LVL)) u_rx_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rxs)
  );

  assign sample = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q != IDLE && !sample) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (state_q != IDLE && !enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && rxs == START_LVL) begin
            // With no half-bit wait the detect cycle is already the start sample.
            if (HALF == 0) begin
              state_d = DATA;
              cnt_d   = CNT_RELOAD;
              bit_d   = '0;
            end else begin
              state_d = START;
              cnt_d   = CNT_START;
            end
          end
        end
        START: begin
          if (sample) begin
            if (rxs == START_LVL) begin
              state_d = DATA;
              cnt_d   = CNT_RELOAD;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            cnt_d   = CNT_RELOAD;
            if (bit_q == BIT_LAST) begin
              state_d = PARITY;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample) begin
            par_d   = rxs;
            cnt_d   = CNT_RELOAD;
            state_d = STOP;
          end
        end
        STOP: begin
          if (sample) begin
            state_d = (rxs == STOP_LVL) ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rxs == IDLE_LVL) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = (state_q != IDLE);
    if (state_q == STOP && enable && sample) begin
      if (rxs == STOP_LVL) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        perr_d  = (par_q != parity_even(shift_q));
      end else begin
        ferr_d  = 1'b1;
      end
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: doc/rx_module.md
Name: rx_module

Overview:
- Serial receiver; the receive end of the frame that tx_module drives.
- Watches the `rx` line, detects the start bit and samples 8 data bits (LSB first), an even-parity bit and a stop bit.
- Presents the received byte with a one-cycle `valid` pulse and error flags.
- Sits between the serial pin and byte-level consumers (FIFO/controller).

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit; must be >= 1. With 1, the line runs at one bit per clk, matching tx_module.

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  receiver enable; 0 = ignore line / abort frame
- rx  input  1  serial line; idle high
- data_out  output  8  last received byte; holds until next valid frame
- valid  output  1  one-cycle pulse: new byte on data_out
- parity_err  output  1  qualifies valid: parity mismatch on this byte
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Frame format: start bit 0, then d[0]..d[7], then parity P = XOR(d[7:0]) (even), then stop bit 1. Total 11 bit times.
- Synchronizer: 2 flops on `rx`, both reset to 1. All decisions use the synchronized value `rxs`, which lags `rx` by 2 clk.
- Reset (reset == 0, asynchronous): state = IDLE, bit counter = 0, clk counter = 0, data_out = 8'h00, valid = 0, parity_err = 0, frame_err = 0, busy = 0.
- Bit-centre sampling: on start detect, the clk counter loads HALF = (CLKS_PER_BIT-1)/2 (integer division). Each subsequent sample is taken CLKS_PER_BIT cycles after the previous one. With CLKS_PER_BIT = 1, every cycle is a sample cycle and the start-detect cycle is the start sample.
- States and transitions:
  - IDLE: if enable && rxs == 0, go to START and load HALF. Otherwise stay.
  - START: at the sample point, if rxs == 0 go to DATA with bit counter = 0. If rxs == 1 (glitch/false start), return to IDLE with no outputs.
  - DATA: at each sample point, shift rxs into shift[7] (right shift, LSB arrives first). After the 8th sample, go to PARITY.
  - PARITY: at the sample point, capture the parity bit and go to STOP.
  - STOP, rxs == 1 at the sample point: on the next cycle data_out = shift, valid = 1, parity_err = (captured parity != XOR(shift)). Go to IDLE.
  - STOP, rxs == 0 at the sample point: on the next cycle frame_err = 1 for one cycle, valid stays 0, data_out is unchanged. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs == 1, then go to IDLE. This prevents a stuck-low or break line from retriggering.
- Latency: valid rises 1 clk after the stop-bit sample. That is 2 + 10*CLKS_PER_BIT + HALF + 1 clk after the falling edge on `rx`.
- Back-to-back frames: IDLE accepts a new start bit on the same cycle valid pulses. There are no dead cycles beyond the stop bit.
- enable deasserted in any non-IDLE state: return to IDLE next cycle. The partial byte is discarded, no valid, no error. data_out is held.
- parity_err is only meaningful when valid = 1, and is 0 otherwise.
- Reset asserted mid-frame: immediate return to reset values. The first start bit after release is accepted only if rxs has been observed high first; the synchronizer resetting to 1 guarantees this.

Decomposition:
- Shared package rx_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}
  - DATA_BITS = 8, START_LVL = 1'b0, STOP_LVL = 1'b1, IDLE_LVL = 1'b1
  - function parity_even(byte)
  - The same constants are to be used by tx_module.
- One sub-module, `bit_sync`: 2-flop synchronizer with async active-low reset to 1. Reusable for other async inputs.

Test Plan:
1. Byte 8'hDD via tx_module, CLKS_PER_BIT = 1, enable = 1 → rx sees 0,1,0,1,1,1,0,1,1,0,1. Response: one valid pulse, data_out = 8'hDD, parity_err = 0, frame_err = 0, busy drops on the cycle after valid.
2. Hand-driven frame 8'hA5 with parity bit forced to 1 (correct is 0) → valid = 1, data_out = 8'hA5, parity_err = 1.
3. Frame 8'h3C with stop bit driven 0, then rx held low 20 clk, then high → frame_err pulses once, no valid, data_out unchanged, no new frame until rx returns high.
4. Two back-to-back frames, 8'h01 then 8'hFE, no idle gap → two valid pulses exactly 11 clk apart with the correct bytes.
5. CLKS_PER_BIT = 4 with a 1-clk low glitch on idle rx → no transition out of START, no valid. A real 4-clk-per-bit frame 8'h55 → data_out = 8'h55 and valid.
6. Reset and enable:
   - reset pulsed low during DATA bit 4 → all outputs 0 immediately, no valid.
   - enable dropped during PARITY → state IDLE next cycle, no valid or error pulses.
